// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Address width, FSM state encoding and the buffered-request bundle.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_XLEN    = 32;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FORCE
  } wb_arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back / long-unit / register-file bundle of the write-port arbiter.
// WB_ARB_PERF_EN adds the conflict and forced-stall counters.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  import wb_arb_pkg::*;

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_waddr;
  logic [XLEN-1:0]       pipe_wdata;
  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_waddr;
  logic [XLEN-1:0]       lu_wdata;
  logic                  lu_ready;
  logic                  stall_pipe;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  pend_busy;
  logic [REG_ADDR_W-1:0] pend_waddr;
`ifdef WB_ARB_PERF_EN
  logic [15:0]           conflict_cnt;
  logic [15:0]           stall_cnt;
`endif

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready, stall_pipe,
    input  rf_we, rf_waddr, rf_wdata,
`ifdef WB_ARB_PERF_EN
    input  conflict_cnt, stall_cnt,
`endif
    input  pend_busy, pend_waddr
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready, stall_pipe,
    output rf_we, rf_waddr, rf_wdata,
`ifdef WB_ARB_PERF_EN
    output conflict_cnt, stall_cnt,
`endif
    output pend_busy, pend_waddr
  );

endinterface

// File: rtl/wb_arb_sat_counter.sv
// Saturating event counter used for the arbiter performance stats.
// Holds at all-ones instead of wrapping.
module wb_arb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count events, stick at the maximum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, long unit buffered.
// Optional WB_ARB_PERF_EN adds conflict_cnt / stall_cnt counters.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int WCW = $clog2(STARVE_LIMIT + 1);

  wb_arb_state_t         state, st_n;
  logic [WCW-1:0]        wait_cnt;
  logic [XLEN-1:0]       buf_data;
  logic                  lu_xfer;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  cap;
  logic                  clr;
  logic                  inc;

  assign lu_xfer = bus.lu_valid && bus.lu_ready;

  // select this cycle's writer and the next state
  always_comb begin
    st_n    = state;
    wr_en   = 1'b0;
    wr_addr = bus.pipe_waddr;
    wr_data = bus.pipe_wdata;
    cap     = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.pipe_we) begin
          wr_en = 1'b1;
          if (lu_xfer && bus.lu_waddr != '0) begin
            cap  = 1'b1;
            st_n = HOLD;
          end
        end else if (lu_xfer) begin
          wr_en   = 1'b1;
          wr_addr = bus.lu_waddr;
          wr_data = bus.lu_wdata;
        end
      end
      HOLD: begin
        wr_en = 1'b1;
        if (!bus.pipe_we) begin
          wr_addr = bus.pend_waddr;
          wr_data = buf_data;
          clr     = 1'b1;
          st_n    = IDLE;
        end else if (bus.pipe_waddr == bus.pend_waddr) begin
          clr  = 1'b1;
          st_n = IDLE;
        end else if (wait_cnt == WCW'(STARVE_LIMIT - 1)) begin
          st_n = FORCE;
        end else begin
          inc = 1'b1;
        end
      end
      FORCE: begin
        wr_en   = 1'b1;
        wr_addr = bus.pend_waddr;
        wr_data = buf_data;
        clr     = 1'b1;
        st_n    = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  // state, holding buffer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      buf_data       <= '0;
      bus.pend_busy  <= 1'b0;
      bus.pend_waddr <= '0;
      bus.lu_ready   <= 1'b0;
      bus.stall_pipe <= 1'b0;
      bus.rf_we      <= 1'b0;
      bus.rf_waddr   <= '0;
      bus.rf_wdata   <= '0;
    end else begin
      state          <= st_n;
      bus.lu_ready   <= (st_n == IDLE);
      bus.stall_pipe <= (st_n == FORCE);
      bus.rf_we      <= wr_en && wr_addr != '0;
      if (wr_en && wr_addr != '0) begin
        bus.rf_waddr <= wr_addr;
        bus.rf_wdata <= wr_data;
      end
      if (cap) begin
        bus.pend_busy  <= 1'b1;
        bus.pend_waddr <= bus.lu_waddr;
        buf_data       <= bus.lu_wdata;
        wait_cnt       <= '0;
      end else if (clr) begin
        bus.pend_busy  <= 1'b0;
        bus.pend_waddr <= '0;
        wait_cnt       <= '0;
      end else if (inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  wb_arb_sat_counter #(.W(16)) u_conflict (
    .clk (clk),
    .rst (rst),
    .inc (cap),
    .cnt (bus.conflict_cnt)
  );

  wb_arb_sat_counter #(.W(16)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (state == FORCE),
    .cnt (bus.stall_cnt)
  );
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back stage and a multi-cycle long-latency unit (mul/div result path).
- Pipeline writes have priority; long-unit results go into a one-entry holding buffer.
- A starvation counter forces a one-cycle pipeline stall so the buffered result can drain.
- Sits between write-back/long unit and the register file; exports pending-destination info to the hazard unit.

Parameters:
- XLEN, 32, data width
- STARVE_LIMIT, 4, max pipeline-won cycles a buffered result waits before forcing a stall (min 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pipe_we  in  1  write-back stage requests a register write
- pipe_waddr  in  5  write-back destination register
- pipe_wdata  in  XLEN  write-back data
- lu_valid  in  1  long unit offers a result
- lu_waddr  in  5  long-unit destination register
- lu_wdata  in  XLEN  long-unit result
- lu_ready  out  1  arbiter accepts a long-unit result this cycle
- stall_pipe  out  1  freeze pipeline this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- pend_busy  out  1  holding buffer valid
- pend_waddr  out  5  destination of the buffered result; 0 when empty

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, buffer empty, wait_cnt 0; all outputs 0, including lu_ready while rst is high.
- Register-file outputs are registered: a decision in cycle N appears on rf_* in cycle N+1. rf_we=0 leaves rf_waddr/rf_wdata at their last values.
- Long-unit handshake: transfer when lu_valid && lu_ready. lu_ready=1 only in IDLE (Moore).
- x0 rule: any write with address 0 yields rf_we=0. An lu transfer with lu_waddr=0 is accepted and discarded, never buffered.
- State IDLE:
  - pipe_we only: write pipe.
  - lu transfer only: write lu directly.
  - both: write pipe, capture lu into buffer, wait_cnt=0, go to HOLD.
  - neither: rf_we=0.
- State HOLD (lu_ready=0, pend_busy=1):
  - !pipe_we: write buffer, clear it, go to IDLE.
  - pipe_we with pipe_waddr == pend_waddr: write pipe; squash the buffer (younger write wins); go to IDLE.
  - pipe_we otherwise: write pipe. If wait_cnt == STARVE_LIMIT-1, go to FORCE; else wait_cnt++.
- State FORCE (stall_pipe=1 Moore, lu_ready=0):
  - Write buffer and ignore pipe_we; the stalled pipeline re-presents the same write next cycle.
  - Clear buffer, go to IDLE.
- Bounds: at most STARVE_LIMIT pipeline-won cycles in HOLD, then exactly one FORCE cycle. wait_cnt width is $clog2(STARVE_LIMIT+1).
- Reset mid-operation: any buffered result is lost. The hazard unit must discard in-flight long ops on reset.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined: adds outputs conflict_cnt[15:0] and stall_cnt[15:0]. Both reset to 0 and saturate at 0xFFFF.
  - conflict_cnt increments on each IDLE-to-HOLD transition.
  - stall_cnt increments on each FORCE cycle.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package wb_arb_pkg holds:
  - REG_ADDR_W=5
  - typedef enum logic [1:0] {IDLE, HOLD, FORCE} wb_arb_state_t
  - typedef struct {addr, data} wb_req_t
- Sub-module wb_arb_sat_counter (16-bit saturating counter with inc), instantiated twice under WB_ARB_PERF_EN.

Test Plan:
- Direct pipe write: pipe_we=1, waddr=5, wdata=0xDEADBEEF, no lu → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; lu_ready stays 1.
- Collision then drain: pipe(3,0x11) and lu(7,0x22) in the same cycle → next cycle rf=(3,0x11), pend_busy=1, pend_waddr=7, lu_ready=0. Next idle pipe cycle → rf=(7,0x22), pend_busy=0, lu_ready=1.
- Starvation, STARVE_LIMIT=4: collision, then pipe_we held high with addresses ≠ 7 → 4 pipe writes, then stall_pipe=1 for exactly one cycle with rf=(7,0x22), then IDLE. With WB_ARB_PERF_EN: conflict_cnt=1, stall_cnt=1.
- Same-destination squash: buffer holds (9,0xAA); pipe writes (9,0xBB) → rf=(9,0xBB), buffer cleared, 0xAA never written.
- x0 suppression: pipe(0,0x1) → rf_we=0. lu(0,0x2) accepted with lu_ready=1 → rf_we=0, pend_busy stays 0.
- Async reset in HOLD: assert rst mid-cycle → all outputs 0 immediately; after release state is IDLE, lu_ready=1, pend_busy=0.
